// File: rtl/ma_request_arbiter.sv
// Round-robin arbiter from the BDD pipeline requesters into the MA unit, tagging in-order replies
// with the owning requester ID. Define MA_ARB_STATS_EN to add grant/stall statistics outputs.
module ma_request_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int TAG_DEPTH = 8,
  parameter int TAG_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*128-1:0] asi_req_data,
  input  logic [NUM_REQ-1:0]   asi_req_valid,
  output logic [NUM_REQ-1:0]   asi_req_ready,
  output logic [127:0]         aso_mem_data,
  output logic                 aso_mem_valid,
  input  logic                 aso_mem_ready,
  input  logic [95:0]          asi_mem_data,
  input  logic                 asi_mem_valid,
  output logic [95:0]          aso_result_data,
  output logic [1:0]           aso_result_channel,
  output logic                 aso_result_valid,
  output logic                 orphan_error
`ifdef MA_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grants,
  output logic [15:0]           stat_stall
`endif
);

  // Handshakes: a request transfers on a cycle where valid && ready are both high; valid never
  // waits on ready. Replies and results have no backpressure and transfer whenever valid is high.

  // MA_REQUEST TYPE_2 occupies payload bits [127:126]; 2'd2 is WRITE_NODE_NEXT, 2'd3 is reserved.
  localparam int                TYPE_LSB         = 126;
  localparam logic [1:0]        TYPE_FETCH_NODE  = 2'd0;
  localparam logic [1:0]        TYPE_INSERT_NODE = 2'd1;
  localparam logic [TAG_BITS:0] TAG_FULL_COUNT   = (TAG_BITS + 1)'(TAG_DEPTH);

  logic [1:0]          rrPtr;
  logic [1:0]          nextPtr;
  logic [2:0]          rrCand;
  logic [NUM_REQ-1:0]  expectsReply;
  logic [NUM_REQ-1:0]  eligible;
  logic                canLoad;
  logic                grantHit;
  logic [1:0]          grantIdx;
  logic [127:0]        grantData;
  logic                load;
  logic                push;
  logic                pop;
  logic                tagEmpty;
  logic                tagFull;
  logic                tagRoom;

  logic [1:0]          tagMem [TAG_DEPTH];
  logic [TAG_BITS-1:0] tagWrPtr;
  logic [TAG_BITS-1:0] tagRdPtr;
  logic [TAG_BITS:0]   tagCount;

  always_comb begin
    expectsReply = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      expectsReply[i] = (asi_req_data[i*128+TYPE_LSB +: 2] == TYPE_FETCH_NODE) ||
                        (asi_req_data[i*128+TYPE_LSB +: 2] == TYPE_INSERT_NODE);
    end
  end

  assign tagEmpty = (tagCount == '0);
  assign tagFull  = (tagCount == TAG_FULL_COUNT);
  assign pop      = asi_mem_valid && !tagEmpty;
  // A reply popping this cycle frees the slot a new reply-expecting grant would push into.
  assign tagRoom  = !tagFull || pop;
  assign canLoad  = !aso_mem_valid || aso_mem_ready;
  assign eligible = asi_req_valid & (~expectsReply | {NUM_REQ{tagRoom}});

  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    rrCand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rrCand = {1'b0, rrPtr} + 3'(k);
      if (rrCand >= 3'(NUM_REQ)) rrCand = rrCand - 3'(NUM_REQ);
      if (!grantHit && eligible[rrCand[1:0]]) begin
        grantHit = 1'b1;
        grantIdx = rrCand[1:0];
      end
    end
  end

  assign load      = canLoad && grantHit;
  assign push      = load && expectsReply[grantIdx];
  assign grantData = asi_req_data[grantIdx*128 +: 128];
  assign nextPtr   = (grantIdx == 2'(NUM_REQ - 1)) ? 2'd0 : grantIdx + 2'd1;

  always_comb begin
    asi_req_ready = '0;
    if (load) asi_req_ready[grantIdx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aso_mem_data  <= '0;
      aso_mem_valid <= 1'b0;
      rrPtr         <= '0;
    end else if (canLoad) begin
      if (grantHit) begin
        aso_mem_data  <= grantData;
        aso_mem_valid <= 1'b1;
        rrPtr         <= nextPtr;
      end else begin
        aso_mem_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tagMem[tagWrPtr] <= grantIdx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tagWrPtr <= '0;
      tagRdPtr <= '0;
      tagCount <= '0;
    end else begin
      if (push) tagWrPtr <= tagWrPtr + 1'b1;
      if (pop)  tagRdPtr <= tagRdPtr + 1'b1;
      case ({push, pop})
        2'b10:   tagCount <= tagCount + 1'b1;
        2'b01:   tagCount <= tagCount - 1'b1;
        default: tagCount <= tagCount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aso_result_data    <= '0;
      aso_result_channel <= '0;
      aso_result_valid   <= 1'b0;
      orphan_error       <= 1'b0;
    end else begin
      aso_result_valid <= pop;
      if (pop) begin
        aso_result_data    <= asi_mem_data;
        aso_result_channel <= tagMem[tagRdPtr];
      end
      if (asi_mem_valid && tagEmpty) orphan_error <= 1'b1;
    end
  end

`ifdef MA_ARB_STATS_EN
  logic stallCycle;
  assign stallCycle = (|(asi_req_valid & expectsReply)) && !tagRoom;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load && grantIdx == 2'(i)) stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
      end
      if (stallCycle && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule
